// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and default widths for the dot-product sequencer
package mac_ctrl_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_WEIGHT_WIDTH = 8;
   localparam int DEF_ACCUM_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_LEN_WIDTH = 8;
   localparam int READ_LATENCY = 1;
   typedef enum logic [2:0] {IDLE, RUN, WAIT, CAPTURE, OUTPUT} ctrl_state_t;
endpackage

// File: rtl/mac_addr_gen.sv
// mac_addr_gen: latches request bases/length, walks the element index and forms wrapping read addresses
module mac_addr_gen
   import mac_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  adv,
   input  logic [LEN_WIDTH-1:0]  vec_len,
   input  logic [ADDR_WIDTH-1:0] data_base,
   input  logic [ADDR_WIDTH-1:0] weight_base,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [ADDR_WIDTH-1:0] weight_addr,
   output logic                  first,
   output logic                  last
);
   logic [LEN_WIDTH-1:0] len, idx;
   logic [ADDR_WIDTH-1:0] dbase, wbase;
   // capture the request on load, then advance one element per issued read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len <= '0;
         idx <= '0;
         dbase <= '0;
         wbase <= '0;
      end else if (load) begin
         len <= vec_len;
         idx <= '0;
         dbase <= data_base;
         wbase <= weight_base;
      end else if (adv) begin
         idx <= idx + 1'b1;
      end
   end
   assign data_addr = dbase + ADDR_WIDTH'(idx);
   assign weight_addr = wbase + ADDR_WIDTH'(idx);
   assign first = idx == '0;
   assign last = idx == len - 1'b1;
endmodule

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: sequences operand reads into an external MAC and returns one dot product per request
module mac_dot_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    vec_len,
   input  logic [ADDR_WIDTH-1:0]   data_base,
   input  logic [ADDR_WIDTH-1:0]   weight_base,
   output logic                    busy,
   output logic                    data_rd_en,
   output logic [ADDR_WIDTH-1:0]   data_rd_addr,
   input  logic [DATA_WIDTH-1:0]   data_rd_data,
   output logic                    weight_rd_en,
   output logic [ADDR_WIDTH-1:0]   weight_rd_addr,
   input  logic [WEIGHT_WIDTH-1:0] weight_rd_data,
   output logic                    mac_enable,
   output logic                    mac_clear_accum,
   output logic [DATA_WIDTH-1:0]   mac_data,
   output logic [WEIGHT_WIDTH-1:0] mac_weight,
   input  logic [ACCUM_WIDTH-1:0]  mac_accum,
   output logic [ACCUM_WIDTH-1:0]  result,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    zero_len
);
   ctrl_state_t state;
   logic load, adv, first, last;
   assign load = state == IDLE && start;
   assign adv = state == RUN;
   mac_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_addr (
      .clk(clk),
      .rst(rst),
      .load(load),
      .adv(adv),
      .vec_len(vec_len),
      .data_base(data_base),
      .weight_base(weight_base),
      .data_addr(data_rd_addr),
      .weight_addr(weight_rd_addr),
      .first(first),
      .last(last)
   );
   assign busy = state != IDLE;
   assign data_rd_en = adv;
   assign weight_rd_en = adv;
   // operands are forced to zero whenever the MAC is not consuming them
   assign mac_data = mac_enable ? data_rd_data : '0;
   assign mac_weight = mac_enable ? weight_rd_data : '0;
   // control FSM plus the one-cycle MAC drive that lines up with the read data return
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         result <= '0;
         result_valid <= 1'b0;
         zero_len <= 1'b0;
         mac_enable <= 1'b0;
         mac_clear_accum <= 1'b0;
      end else begin
         mac_enable <= adv;
         mac_clear_accum <= adv && first;
         case (state)
            IDLE: if (start) begin
               if (vec_len == '0) begin
                  result <= '0;
                  zero_len <= 1'b1;
                  result_valid <= 1'b1;
                  state <= OUTPUT;
               end else state <= RUN;
            end
            RUN: if (last) state <= WAIT;
            WAIT: state <= CAPTURE;
            CAPTURE: begin
               result <= mac_accum;
               zero_len <= 1'b0;
               result_valid <= 1'b1;
               state <= OUTPUT;
            end
            OUTPUT: if (result_ready) begin
               result_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: scoreboard bench with behavioural operand memories and accumulator
module tb_mac_dot_ctrl;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, result_ready = 1'b0;
   logic [7:0] vec_len = '0, data_base = '0, weight_base = '0;
   logic busy, data_rd_en, weight_rd_en, mac_enable, mac_clear_accum, result_valid, zero_len;
   logic [7:0] data_rd_addr, weight_rd_addr, weight_rd_data = '0, mac_weight;
   logic [15:0] data_rd_data = '0, mac_data;
   logic [31:0] mac_accum, result;
   logic [15:0] dmem [256];
   logic [7:0] wmem [256];
   logic rst_n;
   logic signed [31:0] prod;
   int checks = 0, failures = 0;
   int en_cnt = 0, clr_cnt = 0, rd_cnt = 0;
   logic [7:0] dlog [4096];
   logic [7:0] wlog [4096];
   typedef struct { logic [31:0] res; logic zl; int lat; } exp_t;
   exp_t exp_q [$];

   mac_dot_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .data_base(data_base),
      .weight_base(weight_base), .busy(busy), .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr),
      .data_rd_data(data_rd_data), .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
      .weight_rd_data(weight_rd_data), .mac_enable(mac_enable), .mac_clear_accum(mac_clear_accum),
      .mac_data(mac_data), .mac_weight(mac_weight), .mac_accum(mac_accum), .result(result),
      .result_valid(result_valid), .result_ready(result_ready), .zero_len(zero_len)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (data_rd_en) data_rd_data <= dmem[data_rd_addr];
      if (weight_rd_en) weight_rd_data <= wmem[weight_rd_addr];
   end

   assign rst_n = ~rst;
   assign prod = 32'($signed(mac_data)) * 32'($signed(mac_weight));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mac_accum <= '0;
      else if (mac_enable) mac_accum <= (mac_clear_accum ? 32'd0 : mac_accum) + prod;
   end

   always @(negedge clk) begin
      if (mac_enable) en_cnt++;
      if (mac_clear_accum) clr_cnt++;
      if (data_rd_en) begin
         dlog[rd_cnt % 4096] = data_rd_addr;
         wlog[rd_cnt % 4096] = weight_rd_addr;
         rd_cnt++;
      end
   end

   function automatic logic [31:0] dot(int len, logic [7:0] db, logic [7:0] wb);
      logic [31:0] s = '0;
      for (int i = 0; i < len; i++)
         s += 32'($signed(dmem[8'(int'(db) + i)])) * 32'($signed(wmem[8'(int'(wb) + i)]));
      return s;
   endfunction

   task automatic issue(input int len, input logic [7:0] db, input logic [7:0] wb, input bit push);
      exp_t e;
      e.res = dot(len, db, wb);
      e.zl = len == 0;
      e.lat = len == 0 ? 1 : len + 3;
      if (push) exp_q.push_back(e);
      start = 1'b1;
      vec_len = 8'(len);
      data_base = db;
      weight_base = wb;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic await_result(output int lat);
      lat = 1;
      while (!result_valid && lat < 600) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!result_valid) begin
         checks++;
         failures++;
         $display("FAIL await_result: result_valid=%0b after %0d cycles, required 1", result_valid, lat);
      end
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, data_rd_en, weight_rd_en, mac_enable, mac_clear_accum, result_valid, zero_len} !== 7'b0 ||
          result !== 32'd0 || data_rd_addr !== 8'd0 || weight_rd_addr !== 8'd0 || mac_data !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%0b rd=%0b en=%0b valid=%0b result=%h, required all 0",
                  busy, data_rd_en, mac_enable, result_valid, result);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int lat, e0, c0;
      exp_t e;
      dmem[0] = 16'd5; dmem[1] = 16'd2; dmem[2] = 16'd10;
      wmem[0] = 8'd3; wmem[1] = 8'd4; wmem[2] = 8'd2;
      e0 = en_cnt; c0 = clr_cnt;
      issue(3, 8'h00, 8'h00, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || result !== 32'd43) begin
         failures++; $display("FAIL basic_result: got %0d, required %0d", result, e.res);
      end
      checks++;
      if (lat !== e.lat) begin failures++; $display("FAIL basic_latency: got %0d, required %0d", lat, e.lat); end
      checks++;
      if (zero_len !== e.zl) begin failures++; $display("FAIL basic_zero_len: got %0b, required %0b", zero_len, e.zl); end
      checks++;
      if (en_cnt - e0 !== 3 || clr_cnt - c0 !== 1) begin
         failures++; $display("FAIL basic_mac_pulses: en=%0d clr=%0d, required en=3 clr=1", en_cnt - e0, clr_cnt - c0);
      end
      handshake();
   endtask

   task automatic test_signed();
      int lat;
      exp_t e;
      dmem[10] = 16'd6; dmem[11] = -16'sd7;
      wmem[20] = 8'hFE; wmem[21] = 8'd3;
      issue(2, 8'd10, 8'd20, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || result !== 32'hFFFFFFDF) begin
         failures++; $display("FAIL signed_result: got %h, required %h", result, e.res);
      end
      checks++;
      if (lat !== e.lat) begin failures++; $display("FAIL signed_latency: got %0d, required %0d", lat, e.lat); end
      handshake();
   endtask

   task automatic test_zero_len();
      int lat, e0, r0;
      exp_t e;
      e0 = en_cnt; r0 = rd_cnt;
      issue(0, 8'h33, 8'h44, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || zero_len !== 1'b1) begin
         failures++; $display("FAIL zero_result: got %h zl=%0b, required %h zl=1", result, zero_len, e.res);
      end
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL zero_latency: got %0d, required 1", lat); end
      handshake();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (en_cnt !== e0 || rd_cnt !== r0) begin
         failures++; $display("FAIL zero_no_pulses: en=%0d rd=%0d, required 0 0", en_cnt - e0, rd_cnt - r0);
      end
   endtask

   task automatic test_wrap();
      int lat, r0;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         dmem[8'(254 + i)] = 16'(i * 100 - 150);
         wmem[8'(253 + i)] = 8'(i * 37 + 1);
      end
      r0 = rd_cnt;
      issue(4, 8'hFE, 8'hFD, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res) begin failures++; $display("FAIL wrap_result: got %h, required %h", result, e.res); end
      checks++;
      if (rd_cnt - r0 !== 4) begin failures++; $display("FAIL wrap_reads: got %0d, required 4", rd_cnt - r0); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dlog[r0 + i] !== 8'(254 + i) || wlog[r0 + i] !== 8'(253 + i)) begin
            failures++;
            $display("FAIL wrap_addr%0d: data=%h weight=%h, required %h %h", i, dlog[r0 + i], wlog[r0 + i],
                     8'(254 + i), 8'(253 + i));
         end
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int lat, r0;
      exp_t e;
      logic [31:0] held;
      dmem[40] = 16'd9; dmem[41] = 16'd1; wmem[50] = 8'd11; wmem[51] = 8'hF9;
      issue(2, 8'd40, 8'd50, 1'b1);
      await_result(lat);
      held = result;
      r0 = rd_cnt;
      vec_len = 8'd1;
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         @(posedge clk);
         #1;
         checks++;
         if (result_valid !== 1'b1 || result !== held || busy !== 1'b1) begin
            failures++; $display("FAIL hold_stable%0d: valid=%0b result=%h busy=%0b, required 1 %h 1",
                                 i, result_valid, result, busy, held);
         end
      end
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res) begin failures++; $display("FAIL hold_result: got %h, required %h", result, e.res); end
      start = 1'b1;
      handshake();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || rd_cnt !== r0) begin
         failures++; $display("FAIL start_ignored: busy=%0b valid=%0b reads=%0d, required 0 0 0",
                              busy, result_valid, rd_cnt - r0);
      end
      dmem[60] = 16'hFFFF; wmem[61] = 8'h80;
      issue(1, 8'd60, 8'd61, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || result !== 32'd128 || lat !== 4) begin
         failures++; $display("FAIL b2b_result: got %h lat=%0d, required %h lat=4", result, lat, e.res);
      end
      handshake();
   endtask

   task automatic test_max_len();
      int lat, e0;
      exp_t e;
      for (int i = 0; i < 256; i++) begin
         dmem[i] = 16'($urandom);
         wmem[i] = 8'($urandom);
      end
      e0 = en_cnt;
      issue(255, 8'($urandom), 8'($urandom), 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res) begin failures++; $display("FAIL max_result: got %h, required %h", result, e.res); end
      checks++;
      if (lat !== e.lat || en_cnt - e0 !== 255) begin
         failures++; $display("FAIL max_timing: lat=%0d en=%0d, required %0d 255", lat, en_cnt - e0, e.lat);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      int lat, c0;
      exp_t e;
      issue(10, 8'd0, 8'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, data_rd_en, weight_rd_en, mac_enable, mac_clear_accum, result_valid, zero_len} !== 7'b0 ||
          result !== 32'd0 || data_rd_addr !== 8'd0 || mac_data !== 16'd0) begin
         failures++; $display("FAIL mid_reset_outputs: busy=%0b rd=%0b en=%0b valid=%0b, required all 0",
                              busy, data_rd_en, mac_enable, result_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      dmem[0] = 16'd7; wmem[0] = 8'hFF;
      c0 = clr_cnt;
      issue(1, 8'd0, 8'd0, 1'b1);
      await_result(lat);
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || result !== 32'hFFFFFFF9 || clr_cnt - c0 !== 1) begin
         failures++; $display("FAIL mid_reset_recover: got %h clr=%0d, required %h clr=1", result, clr_cnt - c0, e.res);
      end
      handshake();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin dmem[i] = '0; wmem[i] = '0; end
      test_reset();
      test_basic();
      test_signed();
      test_zero_len();
      test_wrap();
      test_back_to_back();
      test_max_len();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
